// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern and active-low hex segment table.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Segments g..a, active-low; entry 15 listed first so element index equals nibble value.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [SEG_W-1:0] seg_lookup(input logic [NIB_W-1:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern (g..a).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = seg_lookup(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-boundary (tear-free) data latching.
// Optional leading-zero blanking is enabled by defining SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    in_clk,
  input  logic                    reset,
  input  logic [NIB_W*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic                    update,
  input  logic                    enable,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [DIGITS-1:0]       an_out,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = NIB_W * DIGITS;
  localparam logic [CNT_W-1:0]  PRESC_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = '1;

  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_done_q, frame_done_d;

  logic              tick_c, wrap_c;
  logic [NIB_W-1:0]  cur_nib_c;
  logic              cur_dp_c, cur_blank_c;
  logic [DIGITS-1:0] blank_c;
  logic [SEG_W-1:0]  dec_seg_c;

  // Digit i is blanked when it and every more-significant active nibble are zero.
  always_comb begin
    blank_c = '0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        zero_run   = zero_run && (act_val_q[i*NIB_W +: NIB_W] == '0);
        blank_c[i] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    cur_nib_c   = '0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c   = act_val_q[i*NIB_W +: NIB_W];
        cur_dp_c    = act_dp_q[i];
        cur_blank_c = blank_c[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i (cur_nib_c),
    .seg_c    (dec_seg_c)
  );

  // Prescaler, digit index, shadow registers and registered display outputs.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;

    tick_c       = enable && (presc_q == PRESC_LAST);
    wrap_c       = tick_c && (idx_q == IDX_LAST);
    frame_done_d = wrap_c;

    if (enable) begin
      presc_d = tick_c ? '0 : presc_q + CNT_W'(1);
    end
    if (tick_c) begin
      idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    end

    if (update) begin
      pend_val_d  = value_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
    // An update landing on the wrap cycle bypasses the pending shadow.
    if (wrap_c) begin
      if (update) begin
        act_val_d = value_in;
        act_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end

    // The tick cycle produces the dead (all-anodes-off) cycle at the start of the next slot.
    if (enable && !tick_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = cur_blank_c ? SEG_BLANK : dec_seg_c;
      dp_d  = ~cur_dp_c;
    end
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule
